vote_session_arbiter: RTL and testbench
=======================================

VOTE_SESSION_ARBITER -- requirements
Module: vote_session_arbiter

Interface
REQ-001 Parameter LOCKOUT_CYCLES, default 100000000, post-vote lockout length in clocks (1 s at 100 MHz), range 1..2^32-1.
REQ-002 Parameter DISPLAY_CYCLES, default 200000000, dwell per candidate in result scan, range 1..2^32-1.
REQ-003 clock  input  1  rising-edge system clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 open_session  input  1  one-cycle pulse; opens voting.
REQ-006 close_session  input  1  one-cycle pulse; closes voting.
REQ-007 vote_valid  input  4  one-cycle debounced vote pulses; bit i = candidate i.
REQ-008 inc_ready  input  1  logger accepts increment this cycle.
REQ-009 inc_valid  output  1  increment request to logger.
REQ-010 inc_sel  output  2  candidate index to increment; stable while inc_valid=1.
REQ-011 busy_led  output  1  high in WAIT and LOCKOUT.
REQ-012 state  output  2  IDLE=00, OPEN=01, LOCKOUT=10, RESULTS=11; WAIT reports 01.
REQ-013 disp_en  output  1  result display enable.
REQ-014 disp_sel  output  2  candidate shown in RESULTS.
REQ-015 dropped  output  1  one-cycle pulse when a vote is discarded.
REQ-016 total_accepted  output  16  accepted votes this session, saturating.

Function
REQ-017 The block SHALL be a registered FSM: IDLE, OPEN, WAIT, LOCKOUT, RESULTS; all outputs registered.
REQ-018 IDLE: vote_valid and close_session are ignored, with no dropped pulse; open_session goes to OPEN.
REQ-019 OPEN with vote_valid≠0: grant one bit by round-robin, search order ptr+1, ptr+2, ptr+3, ptr (mod 4); next cycle go to WAIT with inc_valid=1 and inc_sel=grant (1-cycle latency). Update ptr to grant.
REQ-020 OPEN with more than one vote_valid bit set: the non-granted bits are discarded, and dropped pulses for 1 cycle.
REQ-021 WAIT: hold inc_valid and inc_sel until inc_valid&inc_ready; in that cycle, increment total_accepted (saturate at 0xFFFF), load lockout counter to 0, and go to LOCKOUT.
REQ-022 LOCKOUT: counter increments each cycle; on count==LOCKOUT_CYCLES-1, go to OPEN. LOCKOUT SHALL last exactly LOCKOUT_CYCLES cycles.
REQ-023 Any vote_valid≠0 in WAIT or LOCKOUT SHALL be discarded with a dropped pulse.
REQ-024 close_session in OPEN goes to RESULTS next cycle. If it coincides with vote_valid, close wins, the votes are dropped, and dropped pulses.
REQ-025 close_session in WAIT SHALL be latched. The handshake completes, the vote is counted, and the FSM then goes directly to RESULTS, skipping LOCKOUT.
REQ-026 close_session in LOCKOUT aborts the lockout and goes to RESULTS next cycle.
REQ-027 open_session is ignored outside IDLE and RESULTS.
REQ-028 RESULTS: disp_en=1, disp_sel starts at 0 and advances every DISPLAY_CYCLES cycles, wrapping 3→0. No increments and no dropped pulses occur in RESULTS.
REQ-029 open_session in RESULTS goes to OPEN and clears disp_en, disp_sel, total_accepted and the close latch.
REQ-030 Counters SHALL be 32-bit unsigned; inc_valid SHALL never be asserted outside WAIT.

Reset
REQ-031 Reset SHALL force, on the next edge, from any state (including mid-handshake and mid-lockout): state=IDLE, ptr=3, counters=0, close latch=0, inc_valid=0, inc_sel=0, busy_led=0, disp_en=0, disp_sel=0, dropped=0, total_accepted=0.
REQ-032 An in-flight request aborted by reset SHALL NOT be counted.

Verification (LOCKOUT_CYCLES=4, DISPLAY_CYCLES=3)
REQ-033 Sequence: reset, then open, vote_valid=0100, inc_ready=1 -> inc_valid=1 and inc_sel=2 one cycle later; total_accepted=1; busy_led high for the handshake plus 4 cycles; state returns to 01.
REQ-034 vote_valid=1111 in OPEN after reset -> inc_sel=0 and dropped=1 pulse; the next lone 1111 after lockout -> inc_sel=1.
REQ-035 inc_ready held 0 for 5 cycles -> inc_valid and inc_sel stable for all 5 cycles; vote_valid=0001 during that time -> dropped pulse and no second request.
REQ-036 close_session in WAIT -> vote counted, then state=11 with no lockout; disp_sel sequence is 0,0,0,1,1,1,2,2,2,3,3,3,0.
REQ-037 Reset asserted in LOCKOUT and in WAIT -> all outputs at reset values next cycle; total_accepted=0; vote_valid in IDLE -> no request and dropped=0.
REQ-038 Force 65535 accepted votes (or preload total_accepted) -> total_accepted stays 0xFFFF after a further accepted vote.

Source files
------------

// File: rtl/vote_session_arbiter.sv
// Voting-session FSM: round-robin grant of debounced votes, valid/ready increment handshake
// to the logger, timed post-vote lockout and a cycling result display. All outputs registered.
module vote_session_arbiter #(
  parameter logic [31:0] LOCKOUT_CYCLES = 32'd100000000,
  parameter logic [31:0] DISPLAY_CYCLES = 32'd200000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        open_session,
  input  logic        close_session,
  input  logic [3:0]  vote_valid,
  input  logic        inc_ready,
  output logic        inc_valid,
  output logic [1:0]  inc_sel,
  output logic        busy_led,
  output logic [1:0]  state,
  output logic        disp_en,
  output logic [1:0]  disp_sel,
  output logic        dropped,
  output logic [15:0] total_accepted
);

  typedef enum logic [2:0] {S_IDLE, S_OPEN, S_WAIT, S_LOCKOUT, S_RESULTS} fsm_t;

  fsm_t        fsm, fsm_n;
  logic [1:0]  ptr, ptr_n;
  logic [31:0] count, count_n;
  logic        close_latch, close_latch_n;
  logic        inc_valid_n, disp_en_n, dropped_n;
  logic [1:0]  inc_sel_n, disp_sel_n;
  logic [15:0] total_q, total_n;
  logic [1:0]  grant;
  logic        multi;

  function automatic logic [1:0] state_code(input fsm_t s);
    case (s)
      S_OPEN, S_WAIT: state_code = 2'b01;
      S_LOCKOUT:      state_code = 2'b10;
      S_RESULTS:      state_code = 2'b11;
      default:        state_code = 2'b00;
    endcase
  endfunction

  // Scan lowest priority first so the last hit is the nearest bit after ptr.
  always_comb begin
    grant = ptr;
    for (int k = 4; k >= 1; k--) begin
      if (vote_valid[2'(ptr + 2'(k))]) grant = 2'(ptr + 2'(k));
    end
  end

  assign multi = (vote_valid & (vote_valid - 4'd1)) != 4'd0;

  always_comb begin
    fsm_n         = fsm;
    ptr_n         = ptr;
    count_n       = count;
    close_latch_n = close_latch;
    inc_valid_n   = inc_valid;
    inc_sel_n     = inc_sel;
    disp_en_n     = disp_en;
    disp_sel_n    = disp_sel;
    dropped_n     = 1'b0;
    total_n       = total_q;
    unique case (fsm)
      S_IDLE: begin
        if (open_session) fsm_n = S_OPEN;
      end
      S_OPEN: begin
        if (close_session) begin
          fsm_n      = S_RESULTS;
          dropped_n  = |vote_valid;
          count_n    = '0;
          disp_en_n  = 1'b1;
          disp_sel_n = 2'd0;
        end else if (|vote_valid) begin
          fsm_n       = S_WAIT;
          inc_valid_n = 1'b1;
          inc_sel_n   = grant;
          ptr_n       = grant;
          dropped_n   = multi;
        end
      end
      S_WAIT: begin
        dropped_n = |vote_valid;
        if (inc_valid && inc_ready) begin
          inc_valid_n = 1'b0;
          count_n     = '0;
          if (total_q != 16'hFFFF) total_n = total_q + 16'd1;
          // A close seen during the handshake skips the lockout entirely.
          if (close_latch || close_session) begin
            fsm_n         = S_RESULTS;
            close_latch_n = 1'b0;
            disp_en_n     = 1'b1;
            disp_sel_n    = 2'd0;
          end else begin
            fsm_n = S_LOCKOUT;
          end
        end else if (close_session) begin
          close_latch_n = 1'b1;
        end
      end
      S_LOCKOUT: begin
        dropped_n = |vote_valid;
        if (close_session) begin
          fsm_n      = S_RESULTS;
          count_n    = '0;
          disp_en_n  = 1'b1;
          disp_sel_n = 2'd0;
        end else if (count == LOCKOUT_CYCLES - 32'd1) begin
          fsm_n   = S_OPEN;
          count_n = '0;
        end else begin
          count_n = count + 32'd1;
        end
      end
      S_RESULTS: begin
        if (open_session) begin
          fsm_n         = S_OPEN;
          disp_en_n     = 1'b0;
          disp_sel_n    = 2'd0;
          total_n       = '0;
          close_latch_n = 1'b0;
          count_n       = '0;
        end else if (count == DISPLAY_CYCLES - 32'd1) begin
          count_n    = '0;
          disp_sel_n = disp_sel + 2'd1;
        end else begin
          count_n = count + 32'd1;
        end
      end
      default: fsm_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fsm         <= S_IDLE;
      ptr         <= 2'd3;
      count       <= '0;
      close_latch <= 1'b0;
      inc_valid   <= 1'b0;
      inc_sel     <= 2'd0;
      busy_led    <= 1'b0;
      state       <= 2'b00;
      disp_en     <= 1'b0;
      disp_sel    <= 2'd0;
      dropped     <= 1'b0;
      total_q     <= '0;
    end else begin
      fsm         <= fsm_n;
      ptr         <= ptr_n;
      count       <= count_n;
      close_latch <= close_latch_n;
      inc_valid   <= inc_valid_n;
      inc_sel     <= inc_sel_n;
      busy_led    <= (fsm_n == S_WAIT) || (fsm_n == S_LOCKOUT);
      state       <= state_code(fsm_n);
      disp_en     <= disp_en_n;
      disp_sel    <= disp_sel_n;
      dropped     <= dropped_n;
      total_q     <= total_n;
    end
  end

  assign total_accepted = total_q;

endmodule

// File: tb/tb_vote_session_arbiter.sv
// Scoreboard bench for vote_session_arbiter with short lockout/display timing.
module tb_vote_session_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        open_session = 1'b0;
  logic        close_session = 1'b0;
  logic [3:0]  vote_valid = 4'b0;
  logic        inc_ready = 1'b0;
  logic        inc_valid;
  logic [1:0]  inc_sel;
  logic        busy_led;
  logic [1:0]  state;
  logic        disp_en;
  logic [1:0]  disp_sel;
  logic        dropped;
  logic [15:0] total_accepted;

  int checks = 0;
  int failures = 0;
  int hs_count = 0;
  logic [1:0] sb_q[$];

  vote_session_arbiter #(.LOCKOUT_CYCLES(32'd4), .DISPLAY_CYCLES(32'd3)) dut (
    .clock(clock), .reset(reset), .open_session(open_session), .close_session(close_session),
    .vote_valid(vote_valid), .inc_ready(inc_ready), .inc_valid(inc_valid), .inc_sel(inc_sel),
    .busy_led(busy_led), .state(state), .disp_en(disp_en), .disp_sel(disp_sel),
    .dropped(dropped), .total_accepted(total_accepted)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_exp(input logic [1:0] sel);
    sb_q.push_back(sel);
  endtask

  task automatic wait_open();
    int n = 0;
    while ((busy_led || state != 2'b01) && n < 50) begin
      tick();
      n++;
    end
    check_eq("wait_open", {busy_led, state}, 3'b001);
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_state"}, state, 2'b00);
    check_eq({tag, "_inc_valid"}, inc_valid, 1'b0);
    check_eq({tag, "_inc_sel"}, inc_sel, 2'd0);
    check_eq({tag, "_busy"}, busy_led, 1'b0);
    check_eq({tag, "_disp_en"}, disp_en, 1'b0);
    check_eq({tag, "_disp_sel"}, disp_sel, 2'd0);
    check_eq({tag, "_dropped"}, dropped, 1'b0);
    check_eq({tag, "_total"}, total_accepted, 16'd0);
  endtask

  task automatic do_open();
    open_session = 1'b1;
    tick();
    open_session = 1'b0;
  endtask

  // Completed handshakes are compared against the expected grant queue.
  always @(negedge clock) begin
    if (inc_valid && inc_ready) begin
      hs_count++;
      if (sb_q.size() == 0) check_eq("sb_unexpected_request", 1, 0);
      else check_eq("inc_sel", inc_sel, sb_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tick();
    tick();
    reset = 1'b0;
    check_reset("reset");

    // Single vote, full handshake and lockout length.
    inc_ready = 1'b1;
    do_open();
    check_eq("open_state", state, 2'b01);
    vote_valid = 4'b0100;
    push_exp(2'd2);
    tick();
    vote_valid = 4'b0;
    check_eq("t1_inc_valid", inc_valid, 1'b1);
    check_eq("t1_wait_state", state, 2'b01);
    check_eq("t1_dropped", dropped, 1'b0);
    n = 0;
    while (busy_led && n < 20) begin
      n++;
      tick();
    end
    check_eq("t1_busy_cycles", n, 5);
    check_eq("t1_state_back", state, 2'b01);
    check_eq("t1_total", total_accepted, 16'd1);

    // Round-robin with all four bits set.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    do_open();
    vote_valid = 4'b1111;
    push_exp(2'd0);
    tick();
    vote_valid = 4'b0;
    check_eq("t2_dropped_multi", dropped, 1'b1);
    tick();
    check_eq("t2_dropped_clear", dropped, 1'b0);
    check_eq("t2_lockout_state", state, 2'b10);
    wait_open();
    vote_valid = 4'b1111;
    push_exp(2'd1);
    tick();
    vote_valid = 4'b0;
    check_eq("t2_dropped_multi2", dropped, 1'b1);
    tick();
    wait_open();

    // Backpressure: request held stable, extra vote dropped.
    inc_ready = 1'b0;
    vote_valid = 4'b1000;
    push_exp(2'd3);
    tick();
    for (int i = 0; i <= 5; i++) begin
      check_eq("t3_hold_valid", inc_valid, 1'b1);
      check_eq("t3_hold_sel", inc_sel, 2'd3);
      check_eq("t3_dropped", dropped, (i == 2) ? 1'b1 : 1'b0);
      vote_valid = (i == 1) ? 4'b0001 : 4'b0000;
      inc_ready = (i == 5);
      tick();
    end
    vote_valid = 4'b0;
    check_eq("t3_after_valid", inc_valid, 1'b0);
    check_eq("t3_after_state", state, 2'b10);
    check_eq("t3_total", total_accepted, 16'd3);
    wait_open();

    // Close while waiting: vote counted, lockout skipped, display scan.
    inc_ready = 1'b0;
    vote_valid = 4'b0010;
    push_exp(2'd1);
    tick();
    vote_valid = 4'b0;
    close_session = 1'b1;
    tick();
    close_session = 1'b0;
    check_eq("t4_wait_state", state, 2'b01);
    check_eq("t4_wait_valid", inc_valid, 1'b1);
    inc_ready = 1'b1;
    tick();
    check_eq("t4_results_state", state, 2'b11);
    check_eq("t4_total", total_accepted, 16'd4);
    check_eq("t4_busy", busy_led, 1'b0);
    check_eq("t4_disp_en", disp_en, 1'b1);
    for (int i = 0; i <= 12; i++) begin
      check_eq("t4_disp_sel", disp_sel, (i / 3) % 4);
      check_eq("t4_results_dropped", dropped, 1'b0);
      check_eq("t4_results_valid", inc_valid, 1'b0);
      vote_valid = 4'b1111;
      tick();
    end
    vote_valid = 4'b0;
    check_eq("t4_still_results", state, 2'b11);

    // Reopen clears the session; close beats a simultaneous vote.
    do_open();
    check_eq("t5_state", state, 2'b01);
    check_eq("t5_total_clear", total_accepted, 16'd0);
    check_eq("t5_disp_en", disp_en, 1'b0);
    check_eq("t5_disp_sel", disp_sel, 2'd0);
    vote_valid = 4'b0001;
    close_session = 1'b1;
    tick();
    vote_valid = 4'b0;
    close_session = 1'b0;
    check_eq("t5_close_state", state, 2'b11);
    check_eq("t5_close_dropped", dropped, 1'b1);
    check_eq("t5_close_valid", inc_valid, 1'b0);
    do_open();
    check_eq("t5_reopen", state, 2'b01);

    // Reset during lockout and during an in-flight request.
    inc_ready = 1'b1;
    vote_valid = 4'b0100;
    push_exp(2'd2);
    tick();
    vote_valid = 4'b0;
    tick();
    check_eq("t6_lockout", state, 2'b10);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset("rst_lockout");
    do_open();
    inc_ready = 1'b0;
    vote_valid = 4'b0100;
    push_exp(2'd2);
    tick();
    vote_valid = 4'b0;
    check_eq("t6_wait_valid", inc_valid, 1'b1);
    reset = 1'b1;
    void'(sb_q.pop_back());
    tick();
    reset = 1'b0;
    check_reset("rst_wait");
    vote_valid = 4'b1111;
    inc_ready = 1'b1;
    tick();
    vote_valid = 4'b0;
    check_eq("t6_idle_dropped", dropped, 1'b0);
    check_eq("t6_idle_valid", inc_valid, 1'b0);
    check_eq("t6_idle_state", state, 2'b00);

    // Saturation of the accepted-vote count.
    do_open();
    force dut.total_q = 16'hFFFE;
    tick();
    release dut.total_q;
    check_eq("t7_preload", total_accepted, 16'hFFFE);
    vote_valid = 4'b0001;
    push_exp(2'd0);
    tick();
    vote_valid = 4'b0;
    tick();
    check_eq("t7_reach_max", total_accepted, 16'hFFFF);
    wait_open();
    vote_valid = 4'b0010;
    push_exp(2'd1);
    tick();
    vote_valid = 4'b0;
    tick();
    check_eq("t7_saturate", total_accepted, 16'hFFFF);

    tick();
    tick();
    check_eq("sb_empty", sb_q.size(), 0);
    check_eq("handshake_count", hs_count, 8);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
